// File: rtl/pixel_coord_tracker_if.sv
// Pixel stream bundle between the camera/VGA source and the coordinate tracker.
// master drives the raw stream; slave is the tracker that returns coordinates and status.
interface pixel_coord_tracker_if #(
    parameter int GRAY_WIDTH   = 8,
    parameter int X_CORD_WIDTH = 10,
    parameter int Y_CORD_WIDTH = 10,
    parameter int FCNT_WIDTH   = 16
);
    logic [GRAY_WIDTH-1:0]   gray_in;
    logic                    pix_valid;
    logic                    HS;
    logic                    VS;
    logic [GRAY_WIDTH-1:0]   gray_out;
    logic                    pix_valid_out;
    logic [X_CORD_WIDTH-1:0] x_cord;
    logic [Y_CORD_WIDTH-1:0] y_cord;
    logic                    line_err;
    logic                    frame_err;
    logic [FCNT_WIDTH-1:0]   frame_cnt;

    modport master (
        output gray_in, pix_valid, HS, VS,
        input  gray_out, pix_valid_out, x_cord, y_cord, line_err, frame_err, frame_cnt
    );

    modport slave (
        input  gray_in, pix_valid, HS, VS,
        output gray_out, pix_valid_out, x_cord, y_cord, line_err, frame_err, frame_cnt
    );
endinterface

// File: rtl/pixel_coord_tracker.sv
// Converts a pixel stream with HS/VS syncs into registered x/y coordinates with aligned gray data,
// checks line and frame geometry with sticky error flags, and counts completed frames.
module pixel_coord_tracker #(
    parameter int   GRAY_WIDTH   = 8,
    parameter int   FRAME_WIDTH  = 640,
    parameter int   FRAME_HEIGHT = 480,
    parameter int   X_CORD_WIDTH = 10,
    parameter int   Y_CORD_WIDTH = 10,
    parameter logic SYNC_ACTIVE  = 1'b1,
    parameter int   FCNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_coord_tracker_if.slave  bus
);
    typedef enum logic [0:0] {
        SYNC_WAIT = 1'b0,
        ACTIVE    = 1'b1
    } state_t;

    localparam logic [X_CORD_WIDTH-1:0] X_LAST = X_CORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [Y_CORD_WIDTH-1:0] Y_LAST = Y_CORD_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [X_CORD_WIDTH:0]   P_EXP  = (X_CORD_WIDTH + 1)'(FRAME_WIDTH);
    localparam logic [Y_CORD_WIDTH:0]   L_EXP  = (Y_CORD_WIDTH + 1)'(FRAME_HEIGHT);
    localparam logic [X_CORD_WIDTH:0]   P_MAX  = {(X_CORD_WIDTH + 1){1'b1}};
    localparam logic [Y_CORD_WIDTH:0]   L_MAX  = {(Y_CORD_WIDTH + 1){1'b1}};

    state_t                  r_state;
    logic                    r_hs;
    logic                    r_vs;
    logic [X_CORD_WIDTH-1:0] r_xcnt;
    logic [Y_CORD_WIDTH-1:0] r_ycnt;
    logic [X_CORD_WIDTH:0]   r_pcnt;
    logic [Y_CORD_WIDTH:0]   r_lines;
    logic [GRAY_WIDTH-1:0]   r_gray;
    logic                    r_pv;
    logic [X_CORD_WIDTH-1:0] r_x;
    logic [Y_CORD_WIDTH-1:0] r_y;
    logic                    r_line_err;
    logic                    r_frame_err;
    logic [FCNT_WIDTH-1:0]   r_fcnt;

    logic                    w_active;
    logic                    w_hs_start;
    logic                    w_vs_start;
    logic                    w_pix;
    logic [X_CORD_WIDTH:0]   w_pcnt_inc;
    logic                    w_line_has;
    logic                    w_line_end;
    logic                    w_frame_end;
    logic                    w_line_bad;
    logic [Y_CORD_WIDTH:0]   w_lines_inc;

    assign w_active    = (r_state == ACTIVE);
    assign w_hs_start  = (bus.HS == SYNC_ACTIVE) && (r_hs != SYNC_ACTIVE);
    assign w_vs_start  = (bus.VS == SYNC_ACTIVE) && (r_vs != SYNC_ACTIVE);
    assign w_pix       = bus.pix_valid && w_active;
    // Pixel count including a pixel arriving in the same cycle as a sync start.
    assign w_pcnt_inc  = (w_pix && (r_pcnt != P_MAX)) ? (r_pcnt + (X_CORD_WIDTH + 1)'(1)) : r_pcnt;
    assign w_line_has  = (w_pcnt_inc != (X_CORD_WIDTH + 1)'(0));
    assign w_line_end  = w_active && w_hs_start && w_line_has;
    assign w_frame_end = w_active && w_vs_start;
    assign w_line_bad  = (w_pcnt_inc != P_EXP);
    // A line with pixels is counted once, whether closed by HS or implicitly by VS.
    assign w_lines_inc = (w_line_has && (r_lines != L_MAX)) ? (r_lines + (Y_CORD_WIDTH + 1)'(1)) : r_lines;

    // Sync edge history, pixel pipeline, FSM and geometry counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SYNC_WAIT;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_xcnt      <= '0;
            r_ycnt      <= '0;
            r_pcnt      <= '0;
            r_lines     <= '0;
            r_gray      <= '0;
            r_pv        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_fcnt      <= '0;
        end else begin
            r_hs   <= bus.HS;
            r_vs   <= bus.VS;
            r_gray <= bus.gray_in;
            r_pv   <= w_pix;
            if (w_pix) begin
                r_x <= r_xcnt;
                r_y <= r_ycnt;
            end

            case (r_state)
                SYNC_WAIT: r_state <= w_vs_start ? ACTIVE : SYNC_WAIT;
                ACTIVE:    r_state <= ACTIVE;
                default:   r_state <= SYNC_WAIT;
            endcase

            if (w_frame_end) begin
                if (w_line_end && w_line_bad) begin
                    r_line_err <= 1'b1;
                end
                if (w_lines_inc != L_EXP) begin
                    r_frame_err <= 1'b1;
                end
                r_fcnt  <= r_fcnt + FCNT_WIDTH'(1);
                r_xcnt  <= '0;
                r_ycnt  <= '0;
                r_pcnt  <= '0;
                r_lines <= '0;
            end else if (w_line_end) begin
                if (w_line_bad) begin
                    r_line_err <= 1'b1;
                end
                r_xcnt  <= '0;
                r_pcnt  <= '0;
                r_lines <= w_lines_inc;
                if (r_ycnt != Y_LAST) begin
                    r_ycnt <= r_ycnt + Y_CORD_WIDTH'(1);
                end
            end else if (w_pix) begin
                r_pcnt <= w_pcnt_inc;
                if (r_xcnt != X_LAST) begin
                    r_xcnt <= r_xcnt + X_CORD_WIDTH'(1);
                end
            end
        end
    end

    assign bus.gray_out      = r_gray;
    assign bus.pix_valid_out = r_pv;
    assign bus.x_cord        = r_x;
    assign bus.y_cord        = r_y;
    assign bus.line_err      = r_line_err;
    assign bus.frame_err     = r_frame_err;
    assign bus.frame_cnt     = r_fcnt;
endmodule

// File: tb/tb_pixel_coord_tracker.sv
// Randomized bench for pixel_coord_tracker on a reduced 8x6 frame, checked against a
// line/frame-level reference model of coordinates, error flags and frame count.
module tb_pixel_coord_tracker;
    localparam int GW  = 8;
    localparam int FW  = 8;
    localparam int FH  = 6;
    localparam int XW  = 3;
    localparam int YW  = 3;
    localparam int FCW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pixel_coord_tracker_if #(.GRAY_WIDTH(GW), .X_CORD_WIDTH(XW), .Y_CORD_WIDTH(YW), .FCNT_WIDTH(FCW)) bus ();

    pixel_coord_tracker #(
        .GRAY_WIDTH(GW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .X_CORD_WIDTH(XW),
        .Y_CORD_WIDTH(YW), .SYNC_ACTIVE(1'b1), .FCNT_WIDTH(FCW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state, in frame/line terms.
    bit synced;
    bit exp_lerr;
    bit exp_ferr;
    int exp_fcnt;
    int line_idx;
    int lines_seen;
    int pend;
    int last_x;
    int last_y;

    task automatic model_reset();
        synced = 1'b0; exp_lerr = 1'b0; exp_ferr = 1'b0; exp_fcnt = 0;
        line_idx = 0; lines_seen = 0; pend = 0; last_x = 0; last_y = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [GW-1:0] g, input logic hs, input logic vs);
        bus.pix_valid = v;
        bus.gray_in   = g;
        bus.HS        = hs;
        bus.VS        = vs;
    endtask

    task automatic idle_cycle(input logic hs, input string nm);
        logic [GW-1:0] g;
        g = GW'($urandom);
        drive(1'b0, g, hs, 1'b0);
        tick();
        checks++;
        if ({bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out} !== {1'b0, XW'(last_x), YW'(last_y), g}) begin
            failures++;
            $display("FAIL %s: got pv=%0d x=%0d y=%0d gray=%0h, expected pv=0 x=%0d y=%0d gray=%0h",
                     nm, bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out, last_x, last_y, g);
        end
    endtask

    // hs_mode: 0 = no HS, 1 = HS pulse after the last pixel, 2 = HS together with the last pixel
    task automatic send_line(input int n, input int hs_mode, input int max_gap);
        logic [GW-1:0] g;
        logic          ev;
        int            ex;
        int            ey;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(max_gap, 0);
            for (int k = 0; k < gap; k++) idle_cycle(1'b0, "idle_hold");
            g = GW'($urandom);
            drive(1'b1, g, (hs_mode == 2) && (i == n - 1), 1'b0);
            tick();
            ex = (i < FW - 1) ? i : FW - 1;
            ey = (line_idx < FH - 1) ? line_idx : FH - 1;
            ev = synced;
            if (synced) begin
                last_x = ex;
                last_y = ey;
            end
            checks++;
            if ({bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out} !== {ev, XW'(last_x), YW'(last_y), g}) begin
                failures++;
                $display("FAIL pixel: got pv=%0d x=%0d y=%0d gray=%0h, expected pv=%0d x=%0d y=%0d gray=%0h",
                         bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out, ev, last_x, last_y, g);
            end
        end
        if (synced) pend += n;
        if (hs_mode == 1) idle_cycle(1'b1, "hs_cycle");
        if (hs_mode != 0) begin
            if (synced && pend > 0) begin
                if (pend != FW) exp_lerr = 1'b1;
                lines_seen++;
                line_idx++;
                pend = 0;
            end
            checks++;
            if (bus.line_err !== exp_lerr) begin
                failures++;
                $display("FAIL line_err: got %0d, expected %0d", bus.line_err, exp_lerr);
            end
            idle_cycle(1'b0, "post_hs");
        end
    endtask

    task automatic send_vs();
        logic [GW-1:0] g;
        g = GW'($urandom);
        drive(1'b0, g, 1'b0, 1'b1);
        tick();
        if (!synced) begin
            synced = 1'b1;
        end else begin
            if (lines_seen + ((pend > 0) ? 1 : 0) != FH) exp_ferr = 1'b1;
            exp_fcnt = (exp_fcnt + 1) % (1 << FCW);
            lines_seen = 0;
            line_idx = 0;
            pend = 0;
        end
        checks++;
        if ({bus.frame_cnt, bus.frame_err, bus.line_err, bus.pix_valid_out, bus.gray_out} !==
            {FCW'(exp_fcnt), exp_ferr, exp_lerr, 1'b0, g}) begin
            failures++;
            $display("FAIL frame_end: got fcnt=%0d ferr=%0d lerr=%0d pv=%0d gray=%0h, expected fcnt=%0d ferr=%0d lerr=%0d pv=0 gray=%0h",
                     bus.frame_cnt, bus.frame_err, bus.line_err, bus.pix_valid_out, bus.gray_out,
                     exp_fcnt, exp_ferr, exp_lerr, g);
        end
        idle_cycle(1'b0, "post_vs");
    endtask

    task automatic test_reset();
        model_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out, bus.line_err, bus.frame_err, bus.frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state: got pv=%0d x=%0d y=%0d gray=%0h lerr=%0d ferr=%0d fcnt=%0d, expected all 0",
                     bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out, bus.line_err, bus.frame_err, bus.frame_cnt);
        end
        rst_n = 1'b1;
        idle_cycle(1'b0, "reset_release");
    endtask

    task automatic test_presync();
        send_line(5, 1, 1);
        send_line(3, 0, 0);
        send_vs();
    endtask

    task automatic test_full_frame();
        for (int l = 0; l < FH; l++) send_line(FW, (l < FH - 1) ? 1 : 0, (l == 0) ? 0 : 1);
        send_vs();
    endtask

    task automatic test_simul_hs();
        for (int l = 0; l < FH; l++) begin
            send_line(FW, 2, 1);
            if (l == 2) send_line(0, 1, 0);
        end
        send_vs();
    endtask

    task automatic test_long_line();
        send_line(FW + 1, 1, 0);
        for (int l = 1; l < FH; l++) send_line(FW, 1, 1);
        send_vs();
    endtask

    task automatic test_short_frame();
        for (int l = 0; l < FH - 1; l++) send_line(FW, 1, 1);
        send_vs();
        for (int l = 0; l < FH; l++) send_line(FW, 2, 0);
        send_vs();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 18; f++) begin
            int nl;
            nl = FH;
            if ($urandom_range(4, 0) == 0) nl = FH - 1 + $urandom_range(2, 0);
            for (int l = 0; l < nl; l++) begin
                int len;
                len = FW;
                if ($urandom_range(6, 0) == 0) len = FW - 1 + $urandom_range(2, 0);
                send_line(len, $urandom_range(2, 1), 2);
                if ($urandom_range(5, 0) == 0) send_line(0, 1, 0);
            end
            send_vs();
        end
    endtask

    task automatic test_reset_midline();
        send_vs();
        for (int l = 0; l < 3; l++) send_line(FW, 1, 0);
        send_line(5, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out, bus.line_err, bus.frame_err, bus.frame_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset: got pv=%0d x=%0d y=%0d gray=%0h lerr=%0d ferr=%0d fcnt=%0d, expected all 0",
                     bus.pix_valid_out, bus.x_cord, bus.y_cord, bus.gray_out, bus.line_err, bus.frame_err, bus.frame_cnt);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        send_line(4, 1, 1);
        send_vs();
        send_line(3, 1, 0);
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_presync();
        test_full_frame();
        test_simul_hs();
        test_long_line();
        test_short_frame();
        test_back_to_back();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
